// File: rtl/aes_top_pack.sv
// Shared types and constants for the frame checker: word counter width,
// chk_err bit positions and the FSM state encoding.
package aes_top_pack;

  localparam int WORD_COUNTER_SIZE = 8;
  localparam int ERR_WIDTH         = 4;

  localparam int ERR_NO_SOP     = 0;
  localparam int ERR_SOP_IN_PKT = 1;
  localparam int ERR_LENGTH     = 2;
  localparam int ERR_NONZERO    = 3;

  typedef logic [WORD_COUNTER_SIZE-1:0] word_cnt_t;
  typedef logic [ERR_WIDTH-1:0]         err_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_REPORT = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST style packet stream: valid/ready handshake with sop/eop framing
// and an empty-bytes field sized for the data bus.
interface avalon_st_if #(
  parameter int DATA_WIDTH = 128
);
  localparam int EMPTY_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

  logic                   valid;
  logic                   ready;
  logic [DATA_WIDTH-1:0]  data;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (output valid, data, sop, eop, empty, input ready);
  modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/frame_checker_stats.sv
// Optional packet/error counters for the frame checker; both wrap at 2^32.
module frame_checker_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done_i,
  input  logic        err_i,
  output logic [31:0] pkt_cnt_o,
  output logic [31:0] err_cnt_o
);

  logic [31:0] pkt_cnt_q;
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (done_i) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (err_i) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/frame_checker.sv
// Packet stream checker: counts beats per packet, flags framing, length and
// nonzero-payload errors, reports once per packet. FRAME_CHECKER_STATS_EN adds counters.
module frame_checker
  import aes_top_pack::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  avalon_st_if.slave  msg_in,
  input  word_cnt_t   exp_word_cnt,
  output logic        chk_done,
  output word_cnt_t   chk_len,
  output err_flags_t  chk_err
`ifdef FRAME_CHECKER_STATS_EN
  ,
  output logic [31:0] stat_pkt_cnt,
  output logic [31:0] stat_err_cnt
`endif
);

  fsm_state_e state_q, state_d;
  word_cnt_t  cnt_q, cnt_d;
  word_cnt_t  exp_q, exp_d;
  err_flags_t err_q, err_d;
  logic       ready_q;
  logic       chk_done_q;
  word_cnt_t  chk_len_q;
  err_flags_t chk_err_q;

  logic accept;
  logic beat_nz;
  logic report_entry;

  assign accept       = msg_in.valid & ready_q;
  assign beat_nz      = (msg_in.data != {DATA_WIDTH{1'b0}}) | (|msg_in.empty);
  assign report_entry = (state_d == ST_REPORT);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (msg_in.sop) begin
            // Only flags left by beats dropped in IDLE survive into the new packet.
            err_d   = err_q & ((err_flags_t'(1) << ERR_NO_SOP) | (err_flags_t'(1) << ERR_NONZERO));
            cnt_d   = word_cnt_t'(1);
            exp_d   = exp_word_cnt;
            state_d = msg_in.eop ? ST_REPORT : ST_IN_PKT;
          end else begin
            err_d[ERR_NO_SOP] = 1'b1;
          end
          if (beat_nz) err_d[ERR_NONZERO] = 1'b1;
        end
      end

      ST_IN_PKT: begin
        if (accept) begin
          if (msg_in.sop) begin
            err_d[ERR_SOP_IN_PKT] = 1'b1;
            cnt_d                 = word_cnt_t'(1);
            exp_d                 = exp_word_cnt;
          end else if (cnt_q == '1) begin
            err_d[ERR_LENGTH] = 1'b1;
          end else begin
            cnt_d = cnt_q + word_cnt_t'(1);
          end
          if (beat_nz)    err_d[ERR_NONZERO] = 1'b1;
          if (msg_in.eop) state_d = ST_REPORT;
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
        err_d   = '0;
      end

      default: state_d = ST_IDLE;
    endcase

    if (report_entry && (cnt_d != exp_d)) err_d[ERR_LENGTH] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      exp_q      <= '0;
      err_q      <= '0;
      ready_q    <= 1'b0;
      chk_done_q <= 1'b0;
      chk_len_q  <= '0;
      chk_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      ready_q    <= (state_d != ST_REPORT);
      chk_done_q <= report_entry;
      if (report_entry) begin
        chk_len_q <= cnt_d;
        chk_err_q <= err_d;
      end
    end
  end

  assign msg_in.ready = ready_q;
  assign chk_done     = chk_done_q;
  assign chk_len      = chk_len_q;
  assign chk_err      = chk_err_q;

`ifdef FRAME_CHECKER_STATS_EN
  frame_checker_stats u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .done_i    (chk_done_q),
    .err_i     (|chk_err_q),
    .pkt_cnt_o (stat_pkt_cnt),
    .err_cnt_o (stat_err_cnt)
  );
`endif

endmodule

// File: tb/tb_frame_checker.sv
// Self-checking bench for frame_checker: directed scenarios plus random packets
// compared against a beat-list reference model. Honors FRAME_CHECKER_STATS_EN.
module tb_frame_checker;
  import aes_top_pack::*;

  localparam int DW   = 128;
  localparam int EW   = $clog2(DW / 8);
  localparam int MAXC = (1 << WORD_COUNTER_SIZE) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH(DW)) msg_in ();

  word_cnt_t  exp_word_cnt;
  logic       chk_done;
  word_cnt_t  chk_len;
  err_flags_t chk_err;
`ifdef FRAME_CHECKER_STATS_EN
  logic [31:0] stat_pkt_cnt;
  logic [31:0] stat_err_cnt;
`endif

  frame_checker #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg_in       (msg_in),
    .exp_word_cnt (exp_word_cnt),
    .chk_done     (chk_done),
    .chk_len      (chk_len),
    .chk_err      (chk_err)
`ifdef FRAME_CHECKER_STATS_EN
    ,
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_err_cnt (stat_err_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: every accepted beat since the last report is kept in a list;
  // a report is produced when an eop beat arrives and the list holds a sop.
  typedef struct {
    bit        sop;
    bit        nz;
    word_cnt_t ex;
  } mbeat_t;

  mbeat_t     mq[$];
  bit         m_report;
  bit         m_ready;
  word_cnt_t  m_len;
  err_flags_t m_err;
  int         m_pkts;
  int         m_errs;

  function automatic void model_report();
    int first_sop = -1;
    int last_sop  = -1;
    int n_sop     = 0;
    int cnt;
    bit any_nz    = 0;
    foreach (mq[i]) begin
      if (mq[i].sop) begin
        if (first_sop < 0) first_sop = i;
        last_sop = i;
        n_sop++;
      end
      any_nz |= mq[i].nz;
    end
    cnt      = mq.size() - last_sop;
    m_len    = (cnt > MAXC) ? word_cnt_t'(MAXC) : word_cnt_t'(cnt);
    m_err    = '0;
    m_err[0] = (first_sop > 0);
    m_err[1] = (n_sop > 1);
    m_err[2] = (cnt > MAXC) || (int'(m_len) != int'(mq[last_sop].ex));
    m_err[3] = any_nz;
    m_report = 1'b1;
    m_ready  = 1'b0;
    m_pkts++;
    if (m_err != 0) m_errs++;
    mq.delete();
  endfunction

  function automatic void model_accept(input bit sop, input bit eop, input bit nz, input word_cnt_t ex);
    bit has_sop = sop;
    mbeat_t b;
    foreach (mq[i]) has_sop |= mq[i].sop;
    b.sop = sop;
    b.nz  = nz;
    b.ex  = ex;
    mq.push_back(b);
    if (eop && has_sop) model_report();
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic cycle(input bit vld, input bit sop, input bit eop, input logic [DW-1:0] d,
                       input logic [EW-1:0] e, input word_cnt_t ex, output bit acc);
    msg_in.valid = vld;
    msg_in.sop   = sop;
    msg_in.eop   = eop;
    msg_in.data  = d;
    msg_in.empty = e;
    exp_word_cnt = ex;
    @(negedge clk);
    check("chk_done", chk_done, m_report);
    check("chk_len", chk_len, m_len);
    check("chk_err", chk_err, m_err);
    check("ready", msg_in.ready, m_ready);
    acc = vld && m_ready;
    if (m_report) begin
      m_report = 1'b0;
      m_ready  = 1'b1;
    end
    if (acc) model_accept(sop, eop, (d != '0) || (e != '0), ex);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, word_cnt_t'($urandom), acc);
  endtask

  // Presents a beat after `gap` idle cycles and holds it until accepted.
  task automatic send_beat(input bit sop, input bit eop, input logic [DW-1:0] d,
                           input logic [EW-1:0] e, input word_cnt_t ex, input int gap);
    bit acc = 1'b0;
    int tries = 0;
    idle(gap);
    while (!acc && tries < 4) begin
      cycle(1'b1, sop, eop, d, e, ex, acc);
      tries++;
    end
  endtask

  task automatic send_pkt(input int len, input word_cnt_t ex, input int gap);
    for (int b = 0; b < len; b++) send_beat(b == 0, b == len - 1, '0, '0, ex, gap);
  endtask

  task automatic do_reset();
    msg_in.valid = 1'b0;
    msg_in.sop   = 1'b0;
    msg_in.eop   = 1'b0;
    msg_in.data  = '0;
    msg_in.empty = '0;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    check("rst_chk_done", chk_done, 1'b0);
    check("rst_chk_len", chk_len, '0);
    check("rst_chk_err", chk_err, '0);
    check("rst_ready", msg_in.ready, 1'b0);
`ifdef FRAME_CHECKER_STATS_EN
    check("rst_stat_pkt", stat_pkt_cnt, '0);
    check("rst_stat_err", stat_err_cnt, '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    m_report = 1'b0;
    m_ready  = 1'b1;
    m_len    = '0;
    m_err    = '0;
    m_pkts   = 0;
    m_errs   = 0;
  endtask

  initial begin
    exp_word_cnt = '0;
    do_reset();
    idle(2);

    // Clean 4-beat packet, back to back.
    send_pkt(4, word_cnt_t'(4), 0);
    idle(2);

    // Single-beat packets: matching and mismatching length, back to back.
    send_beat(1'b1, 1'b1, '0, '0, word_cnt_t'(1), 0);
    send_beat(1'b1, 1'b1, '0, '0, word_cnt_t'(2), 0);
    idle(2);

    // Two stray beats without sop, then a clean 3-beat packet.
    send_beat(1'b0, 1'b0, '0, '0, word_cnt_t'(3), 0);
    send_beat(1'b0, 1'b0, '0, '0, word_cnt_t'(3), 0);
    send_pkt(3, word_cnt_t'(3), 0);
    idle(2);

    // sop, beat, sop, beat, eop.
    send_beat(1'b1, 1'b0, '0, '0, word_cnt_t'(3), 0);
    send_beat(1'b0, 1'b0, '0, '0, word_cnt_t'(3), 0);
    send_beat(1'b1, 1'b0, '0, '0, word_cnt_t'(3), 0);
    send_beat(1'b0, 1'b0, '0, '0, word_cnt_t'(3), 0);
    send_beat(1'b0, 1'b1, '0, '0, word_cnt_t'(3), 0);
    idle(2);

    // Valid toggling, data 0x1 on the middle beat.
    send_beat(1'b1, 1'b0, '0, '0, word_cnt_t'(3), 0);
    send_beat(1'b0, 1'b0, DW'(1), '0, word_cnt_t'(3), 1);
    send_beat(1'b0, 1'b1, '0, '0, word_cnt_t'(3), 1);
    idle(2);

    // Rerun, reset mid-packet: no report, outputs back to zero.
    send_beat(1'b1, 1'b0, '0, '0, word_cnt_t'(3), 0);
    send_beat(1'b0, 1'b0, DW'(1), '0, word_cnt_t'(3), 1);
    do_reset();
    idle(4);

    // Zero expected count, nonzero empty field, counter boundary.
    send_pkt(2, word_cnt_t'(0), 0);
    send_beat(1'b1, 1'b1, '0, EW'(3), word_cnt_t'(1), 0);
    send_pkt(MAXC, word_cnt_t'(MAXC), 0);
    idle(1);
    send_pkt(MAXC + 2, word_cnt_t'(MAXC), 0);
    idle(2);

    // Random packets: stray beats, inner sops, payload errors, gaps, length mismatches.
    for (int p = 0; p < 150; p++) begin
      int        len = $urandom_range(1, 6);
      word_cnt_t ex;
      case ($urandom_range(0, 5))
        0:       ex = word_cnt_t'($urandom_range(0, 7));
        1:       ex = '0;
        default: ex = word_cnt_t'(len);
      endcase
      if ($urandom_range(0, 9) == 0)
        send_beat(1'b0, 1'($urandom_range(0, 1)), '0, '0, word_cnt_t'($urandom), $urandom_range(0, 2));
      for (int b = 0; b < len; b++) begin
        bit              sop = (b == 0) || ($urandom_range(0, 14) == 0);
        bit              nz  = ($urandom_range(0, 11) == 0);
        logic [DW-1:0]   d   = nz ? rnd_data() : '0;
        logic [EW-1:0]   e   = (nz && $urandom_range(0, 1) == 1) ? EW'($urandom) : '0;
        word_cnt_t       bx  = sop ? ex : word_cnt_t'($urandom);
        send_beat(sop, b == len - 1, d, e, bx, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
    end
    idle(3);

`ifdef FRAME_CHECKER_STATS_EN
    check("stat_pkt_rand", stat_pkt_cnt, m_pkts);
    check("stat_err_rand", stat_err_cnt, m_errs);
    do_reset();
    send_pkt(3, word_cnt_t'(3), 0);
    send_pkt(2, word_cnt_t'(5), 1);
    send_pkt(1, word_cnt_t'(1), 0);
    idle(3);
    check("stat_pkt_cnt", stat_pkt_cnt, 32'd3);
    check("stat_err_cnt", stat_err_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_checker.md
FRAME_CHECKER -- requirements
Module: frame_checker

Interface
REQ-001 The parameter list SHALL be: DATA_WIDTH, default 128, width of msg_in.data.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: msg_in  avalon_st_if.slave  DATA_WIDTH data  packet stream consumed (valid, ready, data, sop, eop, empty).
REQ-005 Port: exp_word_cnt  input  WORD_COUNTER_SIZE  expected beats per packet.
REQ-006 Port: chk_done  output  1  one-cycle pulse at packet report.
REQ-007 Port: chk_len  output  WORD_COUNTER_SIZE  beat count of last reported packet.
REQ-008 Port: chk_err  output  4  error flags of last report: [0] no-SOP, [1] SOP-in-packet, [2] length mismatch, [3] nonzero data/empty.

Function
REQ-009 A beat SHALL be accepted only in a cycle where msg_in.valid and msg_in.ready are both high.
REQ-010 The FSM SHALL have states IDLE, IN_PKT and REPORT.
REQ-011 msg_in.ready SHALL be 1 in IDLE and IN_PKT and 0 in REPORT.
REQ-012 An accepted beat with sop in IDLE SHALL: sample exp_word_cnt, set the beat counter to 1, and clear the pending errors.
REQ-013 If that sop beat also carries eop, the FSM SHALL go to REPORT; otherwise it SHALL go to IN_PKT.
REQ-014 An accepted beat without sop in IDLE SHALL be dropped, SHALL set pending no-SOP, and the FSM SHALL stay in IDLE; no-SOP is reported with the next packet.
REQ-015 Each accepted beat in IN_PKT SHALL increment the counter; the counter SHALL saturate at all-ones, and saturation SHALL set length mismatch.
REQ-016 An accepted beat with sop in IN_PKT SHALL set SOP-in-packet, restart the counter at 1, and resample exp_word_cnt; the FSM SHALL stay in IN_PKT, and the earlier partial packet is not reported separately.
REQ-017 An accepted beat with eop in IN_PKT SHALL move the FSM to REPORT.
REQ-018 On entry to REPORT, length mismatch SHALL be set when the final count differs from the sampled exp_word_cnt.
REQ-019 Any accepted beat with nonzero data or nonzero empty SHALL set the nonzero data/empty flag.
REQ-020 REPORT SHALL last exactly one cycle, in which chk_done=1 and chk_len/chk_err update; the FSM SHALL then return to IDLE.
REQ-021 Latency from the eop beat to chk_done SHALL be 1 cycle.
REQ-022 chk_len and chk_err SHALL hold their values until the next REPORT.
REQ-023 exp_word_cnt=0 SHALL always produce a length mismatch.

Reset
REQ-024 While rst_n=0, the block SHALL force: FSM=IDLE, counter=0, pending errors=0, chk_done=0, chk_len=0, chk_err=0, msg_in.ready=0.
REQ-025 After reset release, msg_in.ready SHALL be 1 from the first clock edge.
REQ-026 Reset asserted mid-packet SHALL discard the partial packet with no report.

Configuration
REQ-027 With FRAME_CHECKER_STATS_EN defined, the block SHALL add output stat_pkt_cnt (32 bits), incremented on each chk_done.
REQ-028 With FRAME_CHECKER_STATS_EN defined, the block SHALL add output stat_err_cnt (32 bits), incremented on each chk_done with any chk_err bit set.
REQ-029 Both counters SHALL wrap at 2^32 and SHALL reset to 0.
REQ-030 Without FRAME_CHECKER_STATS_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 WORD_COUNTER_SIZE, the chk_err bit-index constants and the FSM state enum typedef SHALL live in aes_top_pack.
REQ-032 One sub-module, frame_checker_stats, SHALL hold the optional counters, instantiated under the macro.

Verification
REQ-033 Feed 4 back-to-back all-zero beats (sop on beat 1, eop on beat 4) with exp_word_cnt=4 -> one cycle after the eop beat: chk_done=1, chk_len=4, chk_err=0000, ready=0 for that cycle.
REQ-034 Feed a single beat with sop=eop=1 and exp_word_cnt=1 -> chk_len=1, chk_err=0000; with exp_word_cnt=2 -> chk_err=0100.
REQ-035 Send 2 beats without sop, then a 3-beat packet with exp_word_cnt=3 -> the first 2 beats are dropped; report shows chk_len=3, chk_err=0001.
REQ-036 Send sop, a beat, sop, then 2 beats with eop on the last (exp_word_cnt=3) -> chk_len=3, chk_err=0010.
REQ-037 Drive valid toggling 1010 across a 3-beat packet containing data 0x1 on beat 2 -> chk_len=3, chk_err=1000; pulse rst_n mid-packet in a rerun -> no chk_done and outputs return to 0.
REQ-038 With FRAME_CHECKER_STATS_EN defined, send 3 packets, one of them erroneous -> stat_pkt_cnt=3, stat_err_cnt=1.
